exe_mem_pipe_reg: RTL and testbench

//   EXE->MEM pipeline boundary directly downstream of the EXE-stage ALU. Captures the ALU

---
 rtl/exe_mem_pipe_reg_if.sv | 45 ++++
 rtl/exe_mem_pipe_reg.sv | 118 +++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 139 +++++++++++++
 3 files changed

// File: rtl/exe_mem_pipe_reg_if.sv
// Bundle of EXE-side capture, MEM-side handshake and forwarding signals for the EXE->MEM boundary.
// Handshake: a payload moves EXE->boundary when exe_valid & !alu_busy & exe_allowin & !flush,
// and boundary->MEM when mem_valid & mem_ready; mem_* stays stable while mem_valid & !mem_ready.
interface exe_mem_pipe_reg_if #(parameter int XLEN = 64);
  logic            flush;
  logic            exe_valid;
  logic            alu_busy;
  logic [XLEN-1:0] exe_pc;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd;
  logic            reg_wen;
  logic            mem_ren;
  logic            mem_wen;
  logic [2:0]      mem_size;
  logic            exe_allowin;
  logic            mem_ready;
  logic            mem_valid;
  logic [XLEN-1:0] mem_pc;
  logic [XLEN-1:0] mem_alu_out;
  logic [XLEN-1:0] mem_store_data;
  logic [4:0]      mem_rd;
  logic            mem_reg_wen;
  logic            mem_ren_o;
  logic            mem_wen_o;
  logic [2:0]      mem_size_o;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            fwd_load;

  modport slave (
    input  flush, exe_valid, alu_busy, exe_pc, alu_out, store_data, rd, reg_wen,
           mem_ren, mem_wen, mem_size, mem_ready,
    output exe_allowin, mem_valid, mem_pc, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_wen, mem_ren_o, mem_wen_o, mem_size_o, fwd_valid, fwd_rd, fwd_data, fwd_load
  );

  modport master (
    output flush, exe_valid, alu_busy, exe_pc, alu_out, store_data, rd, reg_wen,
           mem_ren, mem_wen, mem_size, mem_ready,
    input  exe_allowin, mem_valid, mem_pc, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_wen, mem_ren_o, mem_wen_o, mem_size_o, fwd_valid, fwd_rd, fwd_data, fwd_load
  );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with optional skid entry; main always holds the older instruction.
// Forwarding reflects the youngest held entry so the bypass network sees the newest rd value.
module exe_mem_pipe_reg #(
  parameter int XLEN    = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  exe_mem_pipe_reg_if.slave   bus,
  output logic [1:0]          dbg_state_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            ren;
    logic            wen;
    logic [2:0]      size;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_e;
  entry_t src;
  logic   allowin;
  logic   valid;
  logic   exe_fire;
  logic   mem_fire;
  logic   has_rd;

  assign in_e = '{pc: bus.exe_pc, alu: bus.alu_out, sd: bus.store_data, rd: bus.rd,
                  reg_wen: bus.reg_wen, ren: bus.mem_ren, wen: bus.mem_wen, size: bus.mem_size};

  // With the skid entry, allowin never looks at mem_ready; without it, it must.
  assign allowin  = SKID_EN ? (state_q != S_TWO) : ((state_q == S_EMPTY) || bus.mem_ready);
  assign valid    = (state_q != S_EMPTY);
  assign exe_fire = bus.exe_valid & ~bus.alu_busy & allowin & ~bus.flush;
  assign mem_fire = valid & bus.mem_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (exe_fire) begin
            state_d = S_ONE;
            main_d  = in_e;
          end
        end
        S_ONE: begin
          if (exe_fire && mem_fire) begin
            main_d = in_e;
          end else if (exe_fire) begin
            state_d = S_TWO;
            skid_d  = in_e;
          end else if (mem_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (mem_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.exe_allowin    = allowin;
  assign bus.mem_valid      = valid;
  assign bus.mem_pc         = main_q.pc;
  assign bus.mem_alu_out    = main_q.alu;
  assign bus.mem_store_data = main_q.sd;
  assign bus.mem_rd         = main_q.rd;
  assign bus.mem_reg_wen    = main_q.reg_wen;
  assign bus.mem_ren_o      = main_q.ren;
  assign bus.mem_wen_o      = main_q.wen;
  assign bus.mem_size_o     = main_q.size;

  assign src    = (state_q == S_TWO) ? skid_q : main_q;
  assign has_rd = valid & (src.rd != 5'd0);

  assign bus.fwd_valid = has_rd & src.reg_wen & ~src.ren;
  assign bus.fwd_load  = has_rd & src.ren;
  assign bus.fwd_rd    = valid ? src.rd : 5'd0;
  assign bus.fwd_data  = valid ? src.alu : '0;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed plus random bench for exe_mem_pipe_reg with an occupancy model and expected-payload queue.
module tb_exe_mem_pipe_reg;
  localparam int XLEN = 64;
  localparam int PW   = 3 * XLEN + 11;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  exe_mem_pipe_reg_if #(.XLEN(XLEN)) bus ();

  exe_mem_pipe_reg #(.XLEN(XLEN), .SKID_EN(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clock = ~clock;

  logic [PW-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  zeroed = 1'b0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model at the edge, then check all outputs.
  task automatic step(input bit rst, input bit fl, input bit v, input bit busy, input bit rdy,
                      input logic [XLEN-1:0] alu, input logic [4:0] rdv,
                      input bit rw, input bit ren, input bit wen);
    logic [PW-1:0]   word;
    logic [PW-1:0]   y;
    logic [PW-1:0]   obs;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] sd;
    logic [2:0]      sz;
    bit acc;
    bit cons;
    pc = {$urandom, $urandom};
    sd = {$urandom, $urandom};
    sz = 3'($urandom_range(0, 7));
    reset          = rst;
    bus.flush      = fl;
    bus.exe_valid  = v;
    bus.alu_busy   = busy;
    bus.mem_ready  = rdy;
    bus.exe_pc     = pc;
    bus.alu_out    = alu;
    bus.store_data = sd;
    bus.rd         = rdv;
    bus.reg_wen    = rw;
    bus.mem_ren    = ren;
    bus.mem_wen    = wen;
    bus.mem_size   = sz;
    word = {pc, alu, sd, rdv, rw, ren, wen, sz};
    @(posedge clock);
    acc  = v && !busy && (exp_q.size() < 2) && !fl && !rst;
    cons = (exp_q.size() > 0) && rdy;
    if (rst) begin
      exp_q.delete();
      zeroed = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(word);
        zeroed = 1'b0;
      end
    end
    #1;
    chk("mem_valid", PW'(bus.mem_valid), PW'(exp_q.size() > 0));
    chk("exe_allowin", PW'(bus.exe_allowin), PW'(exp_q.size() < 2));
    chk("state", PW'(dbg_state), PW'(exp_q.size()));
    obs = {bus.mem_pc, bus.mem_alu_out, bus.mem_store_data, bus.mem_rd, bus.mem_reg_wen,
           bus.mem_ren_o, bus.mem_wen_o, bus.mem_size_o};
    if (exp_q.size() > 0) begin
      chk("mem_payload", obs, exp_q[0]);
      y = exp_q[exp_q.size() - 1];
      chk("fwd_valid", PW'(bus.fwd_valid), PW'(y[5] && (y[10:6] != 5'd0) && !y[4]));
      chk("fwd_load", PW'(bus.fwd_load), PW'(y[4] && (y[10:6] != 5'd0)));
      chk("fwd_rd", PW'(bus.fwd_rd), PW'(y[10:6]));
      chk("fwd_data", PW'(bus.fwd_data), PW'(y[138:75]));
    end else begin
      if (zeroed) chk("payload_zero", obs, '0);
      chk("fwd_empty", PW'({bus.fwd_valid, bus.fwd_load, bus.fwd_rd, bus.fwd_data}), '0);
    end
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 64'h0, 5'd0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 64'h5, 5'd3, 1, 0, 0);
    // basic capture with MEM ready, then drain
    step(0, 0, 1, 0, 1, 64'h10, 5'd5, 1, 0, 0);
    step(0, 0, 0, 0, 1, 64'h0, 5'd0, 0, 0, 0);
    // fill both entries while MEM stalls, extra offer rejected, then ordered drain
    step(0, 0, 1, 0, 0, 64'hA0A0, 5'd1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 64'hB0B0, 5'd2, 1, 0, 1);
    step(0, 0, 1, 0, 0, 64'hC0C0, 5'd3, 1, 0, 0);
    step(0, 0, 1, 0, 0, 64'hC0C1, 5'd4, 1, 0, 0);
    step(0, 0, 0, 0, 1, 64'h0, 5'd0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 64'h0, 5'd0, 0, 0, 0);
    // ALU busy blocks capture for 8 cycles
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 64'hD00D, 5'd9, 1, 0, 0);
    step(0, 0, 1, 0, 0, 64'hD00D, 5'd9, 1, 0, 0);
    step(0, 0, 1, 1, 1, 64'h0, 5'd0, 0, 0, 0);
    // flush from TWO with MEM stalled and EXE offering
    step(0, 0, 1, 0, 0, 64'h1111, 5'd10, 1, 0, 0);
    step(0, 0, 1, 0, 0, 64'h2222, 5'd11, 1, 0, 0);
    step(0, 1, 1, 0, 0, 64'h3333, 5'd12, 1, 0, 0);
    // load forwarding, then rd=0 youngest
    step(0, 0, 1, 0, 0, 64'h4000, 5'd7, 1, 1, 0);
    step(0, 0, 1, 0, 0, 64'h5000, 5'd0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 64'h0, 5'd0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 64'h0, 5'd0, 0, 0, 0);
    // back-to-back replace in ONE
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 64'(i * 3 + 1), 5'(i + 20), 1, 0, 0);
    // random traffic
    for (int i = 0; i < 80; i++)
      step(0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    // reset while holding two entries
    step(0, 0, 1, 0, 0, 64'h6000, 5'd13, 1, 0, 0);
    step(0, 0, 1, 0, 0, 64'h7000, 5'd14, 1, 0, 0);
    step(1, 0, 1, 0, 0, 64'h8000, 5'd15, 1, 0, 0);
    step(0, 0, 0, 0, 0, 64'h0, 5'd0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
